adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter.sv | 166 ++++++++++++++++
 tb/tb_adder_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// adder_arbiter: NREQ requesters share one WIDTH-bit adder through a
// round-robin arbiter; the result lands in a single-entry output register
// with a valid/ready handshake toward the consumer.
// Optional feature macro: ADDER_ARBITER_ZERO_FLAG_EN (registered zero flag).
module adder_arbiter #(
    parameter int WIDTH  = 32,
    parameter int NREQ   = 4,
    parameter int IDW    = 2,
    parameter int SWIDTH = WIDTH + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_x,
    input  logic [NREQ*WIDTH-1:0]   req_y,
    input  logic [NREQ-1:0]         req_cin,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [SWIDTH-1:0]       rsp_sum,
    output logic                    rsp_zero
);

    // One extra bit so ptr + offset never overflows before the wrap.
    localparam int CW = IDW + 1;

    logic [IDW-1:0]    ptr_q, ptr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]    rsp_id_q, rsp_id_d;
    logic [SWIDTH-1:0] rsp_sum_q, rsp_sum_d;

    logic [CW-1:0]     cand_s;
    logic [IDW-1:0]    grant_idx_s;
    logic              grant_any_s;
    logic [NREQ-1:0]   grant_s;
    logic              can_accept_s;
    logic              accept_s;
    logic [WIDTH-1:0]  x_s;
    logic [WIDTH-1:0]  y_s;
    logic              cin_s;
    logic [SWIDTH-1:0] sum_s;

    // Round-robin search: walk offsets from ptr, wrapping at NREQ, first valid wins.
    always_comb begin
        grant_idx_s = '0;
        grant_any_s = 1'b0;
        cand_s      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_s = {1'b0, ptr_q} + CW'(k);
            if (cand_s >= CW'(NREQ)) begin
                cand_s = cand_s - CW'(NREQ);
            end else begin
                cand_s = cand_s;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!grant_any_s && (cand_s == CW'(i)) && req_valid[i]) begin
                    grant_any_s = 1'b1;
                    grant_idx_s = IDW'(i);
                end else begin
                    grant_any_s = grant_any_s;
                end
            end
        end
    end

    // Operand mux for the granted requester, then the single shared adder.
    always_comb begin
        x_s   = '0;
        y_s   = '0;
        cin_s = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx_s == IDW'(i)) begin
                x_s   = req_x[i*WIDTH +: WIDTH];
                y_s   = req_y[i*WIDTH +: WIDTH];
                cin_s = req_cin[i];
            end else begin
                x_s = x_s;
            end
        end
        sum_s = {1'b0, x_s} + {1'b0, y_s} + {{(SWIDTH-1){1'b0}}, cin_s};
    end

    // Handshake: a grant is offered only when the output slot is free or draining, never in reset.
    always_comb begin
        can_accept_s = rst_n && (!rsp_valid_q || rsp_ready);
        accept_s     = can_accept_s && grant_any_s;
        grant_s      = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant_s[i] = grant_any_s && (grant_idx_s == IDW'(i));
        end
        if (can_accept_s) begin
            req_ready = grant_s;
        end else begin
            req_ready = '0;
        end
    end

    // Next-state for pointer and output register (EMPTY/FULL with reload).
    always_comb begin
        ptr_d       = ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        if (accept_s) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = grant_idx_s;
            rsp_sum_d   = sum_s;
            if (grant_idx_s == IDW'(NREQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx_s + IDW'(1);
            end
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end else begin
            rsp_valid_d = rsp_valid_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;

`ifdef ADDER_ARBITER_ZERO_FLAG_EN
    logic rsp_zero_q, rsp_zero_d;

    // Zero flag captured together with the sum it describes.
    always_comb begin
        if (accept_s) begin
            rsp_zero_d = (sum_s == '0);
        end else begin
            rsp_zero_d = rsp_zero_q;
        end
    end

    // Zero flag register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_zero_q <= 1'b0;
        end else begin
            rsp_zero_q <= rsp_zero_d;
        end
    end

    assign rsp_zero = rsp_zero_q;
`else
    assign rsp_zero = 1'b0;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter (default parameters).
module tb_adder_arbiter;

    localparam int WIDTH  = 32;
    localparam int NREQ   = 4;
    localparam int IDW    = 2;
    localparam int SWIDTH = WIDTH + 1;
`ifdef ADDER_ARBITER_ZERO_FLAG_EN
    localparam logic ZF = 1'b1;
`else
    localparam logic ZF = 1'b0;
`endif

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_x;
    logic [NREQ*WIDTH-1:0] req_y;
    logic [NREQ-1:0]       req_cin;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [SWIDTH-1:0]     rsp_sum;
    logic                  rsp_zero;

    int n_pass;
    int n_total;

    adder_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_zero  (rsp_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [IDW-1:0]    id;
        logic [WIDTH-1:0]  x;
        logic [WIDTH-1:0]  y;
        logic              cin;
        logic [SWIDTH-1:0] sum;
        logic              zero;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rsp(input string name, input logic v, input logic [IDW-1:0] id,
                           input logic [SWIDTH-1:0] sum);
        chk({name, ".valid"}, 64'(rsp_valid), 64'(v));
        chk({name, ".id"},    64'(rsp_id),    64'(id));
        chk({name, ".sum"},   64'(rsp_sum),   64'(sum));
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;

        vecs[0] = '{id: 2'd2, x: 32'hFFFF_FFFF, y: 32'h0000_0001, cin: 1'b1, sum: 33'h1_0000_0001, zero: 1'b0};
        vecs[1] = '{id: 2'd0, x: 32'h0000_0000, y: 32'h0000_0000, cin: 1'b0, sum: 33'h0_0000_0000, zero: ZF};
        vecs[2] = '{id: 2'd3, x: 32'hFFFF_FFFF, y: 32'hFFFF_FFFF, cin: 1'b1, sum: 33'h1_FFFF_FFFF, zero: 1'b0};
        vecs[3] = '{id: 2'd1, x: 32'h1234_5678, y: 32'h1111_1111, cin: 1'b0, sum: 33'h0_2345_6789, zero: 1'b0};
        vecs[4] = '{id: 2'd1, x: 32'h7FFF_FFFF, y: 32'h0000_0000, cin: 1'b1, sum: 33'h0_8000_0000, zero: 1'b0};

        // Reset with every requester asking.
        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_x     = '0;
        req_y     = '0;
        req_cin   = 4'hF;
        rsp_ready = 1'b1;
        tick();
        tick();
        chk("reset.req_ready", 64'(req_ready), 64'h0);
        chk_rsp("reset", 1'b0, 2'd0, 33'h0);
        chk("reset.zero", 64'(rsp_zero), 64'h0);

        // Single-requester vectors; other lanes carry junk to expose a wrong mux.
        rst_n = 1'b1;
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < NREQ; i++) begin
                req_x[i*WIDTH +: WIDTH] = 32'hDEAD_0000 + 32'(i);
                req_y[i*WIDTH +: WIDTH] = 32'h0BAD_0000 + 32'(i);
            end
            req_cin   = 4'hF;
            req_valid = 4'b0001 << vecs[v].id;
            req_x[vecs[v].id*WIDTH +: WIDTH] = vecs[v].x;
            req_y[vecs[v].id*WIDTH +: WIDTH] = vecs[v].y;
            req_cin[vecs[v].id] = vecs[v].cin;
            #1;
            chk($sformatf("vec%0d.req_ready", v), 64'(req_ready), 64'(4'b0001 << vecs[v].id));
            tick();
            chk_rsp($sformatf("vec%0d", v), 1'b1, vecs[v].id, vecs[v].sum);
            chk($sformatf("vec%0d.zero", v), 64'(rsp_zero), 64'(vecs[v].zero));
        end

        // Fairness from a fresh reset: all valid, consumer always ready.
        rst_n     = 1'b0;
        req_valid = '0;
        tick();
        rst_n = 1'b1;
        req_cin = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_x[i*WIDTH +: WIDTH] = 32'(i + 1);
            req_y[i*WIDTH +: WIDTH] = 32'd100;
        end
        req_valid = 4'hF;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("rr%0d.req_ready", c), 64'(req_ready), 64'(4'b0001 << (c % NREQ)));
            tick();
            chk_rsp($sformatf("rr%0d", c), 1'b1, IDW'(c % NREQ), SWIDTH'(101 + (c % NREQ)));
        end

        // Backpressure: result from requester 0 must hold while req 1 waits.
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp%0d.req_ready", c), 64'(req_ready), 64'h0);
            tick();
            chk_rsp($sformatf("bp%0d", c), 1'b1, 2'd0, 33'd101);
        end
        rsp_ready = 1'b1;
        #1;
        chk("reload.req_ready", 64'(req_ready), 64'b0010);
        tick();
        chk_rsp("reload", 1'b1, 2'd1, 33'd102);
        req_valid = '0;
        #1;
        chk("drain.req_ready", 64'(req_ready), 64'h0);
        tick();
        chk("drain.valid", 64'(rsp_valid), 64'h0);

        // Mid-operation reset: fill from requester 2 so ptr would be 3 if not cleared.
        req_x[2*WIDTH +: WIDTH] = 32'd5;
        req_y[2*WIDTH +: WIDTH] = 32'd6;
        req_cin   = 4'b0100;
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        #1;
        chk("mid.fill.req_ready", 64'(req_ready), 64'b0100);
        tick();
        chk_rsp("mid.fill", 1'b1, 2'd2, 33'd12);
        req_valid = 4'b1010;
        rst_n     = 1'b0;
        #1;
        chk("mid.rst.req_ready", 64'(req_ready), 64'h0);
        tick();
        chk_rsp("mid.rst", 1'b0, 2'd0, 33'd0);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        req_cin   = '0;
        #1;
        chk("mid.first.req_ready", 64'(req_ready), 64'b0010);
        tick();
        chk_rsp("mid.first", 1'b1, 2'd1, 33'd102);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
